// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle: position, sync levels, blanking and pacing strobes.
// The generator drives it through master; renderers consume it through slave.
interface vga_sync_gen_if #(
  parameter int unsigned CNT_W = 10
);
  logic [CNT_W-1:0] hpos;
  logic [CNT_W-1:0] vpos;
  logic             hsync;
  logic             vsync;
  logic             display_on;
  logic             line_start;
  logic             frame_start;
  logic [7:0]       frame_count;

  modport master (
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );

  modport slave (
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: one pixel per clk, all outputs registered and
// describing the same (hpos, vpos) so downstream logic sees no skew.
module vga_sync_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FRONT  = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BACK   = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FRONT  = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BACK   = 33,
   parameter bit          SYNC_POL = 1'b0,
   parameter int unsigned CNT_W    = 10
) (
   input logic            clk,
   input logic            rst,
   vga_sync_gen_if.master vga
);

   // One spare bit so boundaries equal to 2**CNT_W still compare correctly.
   typedef logic [CNT_W:0] wide_t;

   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam wide_t H_ACT  = wide_t'(H_ACTIVE);
   localparam wide_t V_ACT  = wide_t'(V_ACTIVE);
   localparam wide_t HS_BEG = wide_t'(H_ACTIVE + H_FRONT);
   localparam wide_t HS_END = wide_t'(H_ACTIVE + H_FRONT + H_SYNC);
   localparam wide_t VS_BEG = wide_t'(V_ACTIVE + V_FRONT);
   localparam wide_t VS_END = wide_t'(V_ACTIVE + V_FRONT + V_SYNC);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] h_q, v_q;
   logic             hs_q, vs_q, de_q, ls_q, fs_q;
   logic [7:0]       fc_q;

   logic [CNT_W-1:0] nh, nv;
   wide_t            nh_w, nv_w;
   logic             wrap;

   // Outputs are decoded from the *next* position so they land with it.
   always_comb begin
      nh   = '0;
      nv   = '0;
      wrap = 1'b0;
      if (state == ST_RUN) begin
         if (h_q == H_LAST) begin
            nh = '0;
            if (v_q == V_LAST) begin
               nv   = '0;
               wrap = 1'b1;
            end else begin
               nv = v_q + CNT_W'(1);
            end
         end else begin
            nh = h_q + CNT_W'(1);
            nv = v_q;
         end
      end
      nh_w = {1'b0, nh};
      nv_w = {1'b0, nv};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         h_q   <= '0;
         v_q   <= '0;
         de_q  <= 1'b0;
         ls_q  <= 1'b0;
         fs_q  <= 1'b0;
         hs_q  <= ~SYNC_POL;
         vs_q  <= ~SYNC_POL;
         fc_q  <= '0;
      end else begin
         state <= ST_RUN;
         h_q   <= nh;
         v_q   <= nv;
         de_q  <= (nh_w < H_ACT) && (nv_w < V_ACT);
         ls_q  <= (nh == '0);
         fs_q  <= (nh == '0) && (nv == '0);
         hs_q  <= ((nh_w >= HS_BEG) && (nh_w < HS_END)) ? SYNC_POL : ~SYNC_POL;
         vs_q  <= ((nv_w >= VS_BEG) && (nv_w < VS_END)) ? SYNC_POL : ~SYNC_POL;
         if (wrap)
            fc_q <= fc_q + 8'd1;
      end
   end

   assign vga.hpos        = h_q;
   assign vga.vpos        = v_q;
   assign vga.hsync       = hs_q;
   assign vga.vsync       = vs_q;
   assign vga.display_on  = de_q;
   assign vga.line_start  = ls_q;
   assign vga.frame_start = fs_q;
   assign vga.frame_count = fc_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default 640x480 raster plus a 15x13 (active-high sync)
// and a 5x5 raster, each checked cycle by cycle against an arithmetic model.
module tb_vga_sync_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1;
   logic rst1 = 1'b1;
   logic rst2 = 1'b1;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   vga_sync_gen_if #(.CNT_W(10)) v0 ();
   vga_sync_gen_if #(.CNT_W(10)) v1 ();
   vga_sync_gen_if #(.CNT_W(3))  v2 ();

   vga_sync_gen u0 (.clk(clk), .rst(rst0), .vga(v0));

   vga_sync_gen #(
      .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
      .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(3),
      .SYNC_POL(1'b1), .CNT_W(10)
   ) u1 (.clk(clk), .rst(rst1), .vga(v1));

   vga_sync_gen #(
      .H_ACTIVE(2), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
      .V_ACTIVE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .CNT_W(3)
   ) u2 (.clk(clk), .rst(rst2), .vga(v2));

   typedef struct {
      int unsigned ha, hf, hs, hb, va, vf, vs, vb;
      bit          pol;
   } cfg_t;

   localparam cfg_t C0 = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
   localparam cfg_t C1 = '{8, 2, 3, 2, 6, 2, 2, 3, 1'b1};
   localparam cfg_t C2 = '{2, 1, 1, 1, 2, 1, 1, 1, 1'b0};

   // {hpos, vpos, hsync, vsync, display_on, line_start, frame_start, frame_count}
   function automatic logic [44:0] pk(int unsigned h, int unsigned v, logic hs, logic vs,
                                      logic de, logic ls, logic fs, logic [7:0] fc);
      return {16'(h), 16'(v), hs, vs, de, ls, fs, fc};
   endfunction

   // Expected outputs t clocks after the first running edge (t=0 presents (0,0)).
   function automatic logic [44:0] model(cfg_t c, int unsigned t);
      int unsigned ht, vt, h, line, v, fr;
      logic hs, vs;
      ht   = c.ha + c.hf + c.hs + c.hb;
      vt   = c.va + c.vf + c.vs + c.vb;
      h    = t % ht;
      line = t / ht;
      v    = line % vt;
      fr   = line / vt;
      hs   = (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
      vs   = (v >= c.va + c.vf && v < c.va + c.vf + c.vs) ? c.pol : !c.pol;
      return pk(h, v, hs, vs, (h < c.ha) && (v < c.va), h == 0, (h == 0) && (v == 0), 8'(fr % 256));
   endfunction

   function automatic logic [44:0] rst_exp(cfg_t c);
      return pk(0, 0, !c.pol, !c.pol, 1'b0, 1'b0, 1'b0, 8'd0);
   endfunction

   function automatic logic [44:0] obs0();
      return pk(32'(v0.hpos), 32'(v0.vpos), v0.hsync, v0.vsync, v0.display_on,
                v0.line_start, v0.frame_start, v0.frame_count);
   endfunction
   function automatic logic [44:0] obs1();
      return pk(32'(v1.hpos), 32'(v1.vpos), v1.hsync, v1.vsync, v1.display_on,
                v1.line_start, v1.frame_start, v1.frame_count);
   endfunction
   function automatic logic [44:0] obs2();
      return pk(32'(v2.hpos), 32'(v2.vpos), v2.hsync, v2.vsync, v2.display_on,
                v2.line_start, v2.frame_start, v2.frame_count);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst0 = 1'b1;
      repeat (3) step();
      n_cmp++;
      if (obs0() !== rst_exp(C0)) begin
         n_bad++;
         $display("FAIL reset: got %h want %h", obs0(), rst_exp(C0));
      end
   endtask

   task automatic test_release();
      rst0 = 1'b0;
      for (int unsigned t = 0; t < 2; t++) begin
         step();
         n_cmp++;
         if (obs0() !== model(C0, t)) begin
            n_bad++;
            $display("FAIL release t=%0d: got %h want %h", t, obs0(), model(C0, t));
         end
      end
      n_cmp++;
      if (v0.hpos !== 10'd1 || v0.line_start !== 1'b0 || v0.frame_start !== 1'b0) begin
         n_bad++;
         $display("FAIL second_edge: hpos=%0d ls=%b fs=%b want 1/0/0",
                  v0.hpos, v0.line_start, v0.frame_start);
      end
   endtask

   // Continues from t=2 through three full lines, then resets at column 300.
   task automatic test_line_scan();
      int unsigned hs_cnt = 0, de_fall = 0, last_ls = 0;
      logic prev_de = 1'b1;
      for (int unsigned t = 2; t < 2400 + 300; t++) begin
         step();
         n_cmp++;
         if (obs0() !== model(C0, t)) begin
            n_bad++;
            $display("FAIL scan t=%0d: got %h want %h", t, obs0(), model(C0, t));
         end
         if (t < 800 && v0.hsync == 1'b0) hs_cnt++;
         if (t < 800 && prev_de && !v0.display_on && de_fall == 0) de_fall = 32'(v0.hpos);
         prev_de = v0.display_on;
         if (v0.line_start) begin
            n_cmp++;
            if (t - last_ls != 800) begin
               n_bad++;
               $display("FAIL ls_period: got %0d want 800", t - last_ls);
            end
            last_ls = t;
         end
      end
      n_cmp++;
      if (hs_cnt != 96) begin
         n_bad++;
         $display("FAIL hsync_width: got %0d want 96", hs_cnt);
      end
      n_cmp++;
      if (de_fall != 640) begin
         n_bad++;
         $display("FAIL de_fall: got %0d want 640", de_fall);
      end
   endtask

   task automatic test_mid_reset();
      n_cmp++;
      if (v0.hpos !== 10'd299) begin
         n_bad++;
         $display("FAIL pre_reset_pos: got %0d want 299", v0.hpos);
      end
      step();
      rst0 = 1'b1;
      step();
      n_cmp++;
      if (obs0() !== rst_exp(C0)) begin
         n_bad++;
         $display("FAIL mid_reset: got %h want %h", obs0(), rst_exp(C0));
      end
      rst0 = 1'b0;
      for (int unsigned t = 0; t < 3; t++) begin
         step();
         n_cmp++;
         if (obs0() !== model(C0, t)) begin
            n_bad++;
            $display("FAIL restart t=%0d: got %h want %h", t, obs0(), model(C0, t));
         end
      end
   endtask

   task automatic test_full_frame();
      int unsigned vs_cnt = 0, fs_seen = 0, last_fs = 0;
      rst1 = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (obs1() !== rst_exp(C1)) begin
         n_bad++;
         $display("FAIL reset1: got %h want %h", obs1(), rst_exp(C1));
      end
      rst1 = 1'b0;
      for (int unsigned t = 0; t < 3 * 195; t++) begin
         step();
         n_cmp++;
         if (obs1() !== model(C1, t)) begin
            n_bad++;
            $display("FAIL frame t=%0d: got %h want %h", t, obs1(), model(C1, t));
         end
         if (t < 195 && v1.vsync == 1'b1) vs_cnt++;
         if (v1.frame_start) begin
            fs_seen++;
            if (fs_seen > 1) begin
               n_cmp++;
               if (t - last_fs != 195) begin
                  n_bad++;
                  $display("FAIL fs_period: got %0d want 195", t - last_fs);
               end
            end
            if (fs_seen == 2) begin
               n_cmp++;
               if (v1.frame_count !== 8'd1) begin
                  n_bad++;
                  $display("FAIL fc_second_frame: got %0d want 1", v1.frame_count);
               end
            end
            last_fs = t;
         end
      end
      n_cmp++;
      if (vs_cnt != 30) begin
         n_bad++;
         $display("FAIL vsync_width: got %0d want 30", vs_cnt);
      end
   endtask

   task automatic test_random_reset();
      for (int unsigned it = 0; it < 16; it++) begin
         int unsigned k, n;
         k = $urandom_range(1, 3);
         n = $urandom_range(1, 700);
         rst1 = 1'b1;
         for (int unsigned r = 0; r < k; r++) begin
            step();
            n_cmp++;
            if (obs1() !== rst_exp(C1)) begin
               n_bad++;
               $display("FAIL rand_reset it=%0d: got %h want %h", it, obs1(), rst_exp(C1));
            end
         end
         rst1 = 1'b0;
         for (int unsigned t = 0; t < n; t++) begin
            step();
            n_cmp++;
            if (obs1() !== model(C1, t)) begin
               n_bad++;
               $display("FAIL rand_run it=%0d t=%0d: got %h want %h", it, t, obs1(), model(C1, t));
            end
         end
      end
   endtask

   task automatic test_wrap();
      int unsigned max_h = 0, max_v = 0;
      rst2 = 1'b1;
      step();
      n_cmp++;
      if (obs2() !== rst_exp(C2)) begin
         n_bad++;
         $display("FAIL reset2: got %h want %h", obs2(), rst_exp(C2));
      end
      rst2 = 1'b0;
      for (int unsigned t = 0; t < 256 * 25 + 30; t++) begin
         step();
         n_cmp++;
         if (obs2() !== model(C2, t)) begin
            n_bad++;
            $display("FAIL wrap_run t=%0d: got %h want %h", t, obs2(), model(C2, t));
         end
         if (32'(v2.hpos) > max_h) max_h = 32'(v2.hpos);
         if (32'(v2.vpos) > max_v) max_v = 32'(v2.vpos);
         if (t == 255 * 25) begin
            n_cmp++;
            if (v2.frame_count !== 8'd255) begin
               n_bad++;
               $display("FAIL fc_255: got %0d want 255", v2.frame_count);
            end
         end
         if (t == 256 * 25) begin
            n_cmp++;
            if (v2.frame_count !== 8'd0) begin
               n_bad++;
               $display("FAIL fc_wrap: got %0d want 0", v2.frame_count);
            end
         end
      end
      n_cmp++;
      if (max_h > 4 || max_v > 4) begin
         n_bad++;
         $display("FAIL small_bounds: max hpos=%0d vpos=%0d want <=4", max_h, max_v);
      end
   endtask

   initial begin
      test_reset();
      test_release();
      test_line_scan();
      test_mid_reset();
      test_full_frame();
      test_random_reset();
      test_wrap();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
